spin_sequencer: RTL and testbench

SPIN_SEQUENCER -- requirements
Module: spin_sequencer

---
 rtl/spin_sequencer.sv | 153 +++++++++++++++
 tb/tb_spin_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_sequencer.sv
// Slot-machine spin sequencer: debounced button, LFSR sprite draw, spin handshake, win strobe.
// Define SPIN_TIMEOUT_EN to add a sticky timeout on the wait for done.
module spin_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 1000,
    parameter int          NUM_SPRITES     = 6,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spin_btn,
    input  logic       done,
    output logic       start_spin,
    output logic [2:0] final1_sprite,
    output logic [2:0] final2_sprite,
    output logic [2:0] final3_sprite,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] win,
    output logic       timeout
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    NS4     = 4'(NUM_SPRITES);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, RESULT} state_t;

    state_t        state;
    state_t        next_state;
    logic          sync1;
    logic          sync2;
    logic          db_level;
    logic          db_prev;
    logic [CW-1:0] db_cnt;
    logic [15:0]   lfsr;
    logic          seen_low;
    logic          press;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    s3;
    logic [1:0]    win_q;
    logic [1:0]    win_next;

    function automatic logic [2:0] fold(input logic [2:0] f);
        logic [3:0] w;
        w = {1'b0, f};
        if (w >= NS4) w = w - NS4;
        return w[2:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
            lfsr     <= LFSR_SEED;
        end else begin
            sync1   <= spin_btn;
            sync2   <= sync1;
            db_prev <= db_level;
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = db_level & ~db_prev;

`ifdef SPIN_TIMEOUT_EN
    logic [23:0] tmo_cnt;
    logic        tmo_flag;
    logic        tmo_hit;

    assign tmo_hit = (state == WAIT_DONE) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 24'd1 : 24'd0;
            if (state == WAIT_DONE && next_state == IDLE) tmo_flag <= 1'b1;
        end
    end

    assign timeout = tmo_flag;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (press) next_state = LOAD;
            LOAD:      next_state = START;
            START:     next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (seen_low && done) next_state = RESULT;
`ifdef SPIN_TIMEOUT_EN
                else if (tmo_hit) next_state = IDLE;
`endif
            end
            RESULT:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        win_next = 2'd0;
        if (s1 == s2 && s2 == s3) win_next = 2'd2;
        else if (s1 == s2 || s2 == s3 || s1 == s3) win_next = 2'd1;
    end

    // seen_low guards against a done level left over from the previous spin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            seen_low <= 1'b0;
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            win_q    <= '0;
        end else begin
            state <= next_state;
            if (state == LOAD) begin
                s1 <= fold(lfsr[2:0]);
                s2 <= fold(lfsr[6:4]);
                s3 <= fold(lfsr[10:8]);
            end
            if (state == START) seen_low <= 1'b0;
            else if (state == WAIT_DONE && !done) seen_low <= 1'b1;
            if (next_state == RESULT) win_q <= win_next;
        end
    end

    assign start_spin    = (state == START);
    assign busy          = (state != IDLE);
    assign result_valid  = (state == RESULT);
    assign win           = win_q;
    assign final1_sprite = s1;
    assign final2_sprite = s2;
    assign final3_sprite = s3;

endmodule

// File: tb/tb_spin_sequencer.sv
// Bench for spin_sequencer: table-driven sprite/win vectors, hand sequences and random spins
// against a transaction-level model (LFSR from seed, latency from the button edge).
module tb_spin_sequencer;

    localparam int          DB   = 4;
    localparam int          NS   = 6;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          TMO  = 50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       spin_btn = 1'b0;
    logic       done = 1'b0;
    logic       start_spin;
    logic [2:0] final1_sprite;
    logic [2:0] final2_sprite;
    logic [2:0] final3_sprite;
    logic       busy;
    logic       result_valid;
    logic [1:0] win;
    logic       timeout;

    spin_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .NUM_SPRITES(NS),
        .LFSR_SEED(SEED),
        .TIMEOUT_CYCLES(24'(TMO))
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .spin_btn(spin_btn),
        .done(done),
        .start_spin(start_spin),
        .final1_sprite(final1_sprite),
        .final2_sprite(final2_sprite),
        .final3_sprite(final3_sprite),
        .busy(busy),
        .result_valid(result_valid),
        .win(win),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] f1, f2, f3;
        logic [2:0] s1, s2, s3;
        logic [1:0] w;
    } vec_t;

    int          nvec = 0;
    int          nmis = 0;
    int          cyc = 0;
    int          n_start = 0;
    int          n_rv = 0;
    logic        texp = 1'b0;
    logic [15:0] model = SEED;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [2:0] fold(input logic [2:0] f);
        return 3'(int'(f) % NS);
    endfunction

    function automatic logic [1:0] score(input logic [2:0] a, b, c);
        int pairs;
        pairs = int'(a == b) + int'(b == c) + int'(a == c);
        return (pairs == 3) ? 2'd2 : (pairs == 1) ? 2'd1 : 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model = step(model);
        n_start += int'(start_spin);
        n_rv += int'(result_valid);
        check("timeout_level", timeout, texp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        texp = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_start", start_spin, 0);
        check("rst_rv", result_valid, 0);
        check("rst_win", win, 0);
        check("rst_sprites", {final1_sprite, final2_sprite, final3_sprite}, 0);
        check("rst_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        model = SEED;
    endtask

    task automatic start_only(output int k0);
        k0 = cyc;
        spin_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("busy_latency", busy, i >= 7);
            check("start_latency", start_spin, i == 8);
        end
    endtask

    task automatic wtick(inout int wt, input bit pw);
        tick();
        wt++;
        check("rv_in_wait", result_valid, 0);
        check("busy_in_wait", busy, 1);
        if (wt == 2) spin_btn = 1'b0;
        if (pw && wt == 8) spin_btn = 1'b1;
    endtask

    task automatic spin(input bit aim, input logic [8:0] want, input int gap,
                        input int hi_len, input int low_len, input bit pw,
                        output logic [2:0] a1, a2, a3, output logic [1:0] aw);
        logic [15:0] p;
        logic [15:0] ld;
        logic [2:0]  e1, e2, e3;
        logic [1:0]  ew;
        int          j, k0, wt, base_s, base_r, g;
        bit          found;
        g = gap;
        a1 = 0; a2 = 0; a3 = 0; aw = 0;
        if (aim) begin
            p = model;
            found = 0;
            j = 0;
            for (int i = 0; i < 70000 && !found; i++) begin
                if (i >= 7 && p[2:0] == want[2:0] && p[6:4] == want[5:3] && p[10:8] == want[8:6]) begin
                    found = 1;
                    j = i;
                end else begin
                    p = step(p);
                end
            end
            if (!found) begin
                check("lfsr_search", 0, 1);
                return;
            end
            g = j - 7;
        end
        repeat (g) tick();
        ld = model;
        repeat (7) ld = step(ld);
        e1 = fold(ld[2:0]);
        e2 = fold(ld[6:4]);
        e3 = fold(ld[10:8]);
        ew = score(e1, e2, e3);
        base_s = n_start;
        base_r = n_rv;
        start_only(k0);
        check("sprite1_after_load", final1_sprite, e1);
        check("sprite2_after_load", final2_sprite, e2);
        check("sprite3_after_load", final3_sprite, e3);
        wt = 0;
        wtick(wt, pw);
        if (hi_len > 0) begin
            done = 1'b1;
            repeat (hi_len) wtick(wt, pw);
        end
        done = 1'b0;
        repeat (low_len) wtick(wt, pw);
        done = 1'b1;
        tick();
        check("rv_after_done", result_valid, 1);
        check("win_result", win, ew);
        check("sprites_result", {final1_sprite, final2_sprite, final3_sprite}, {e1, e2, e3});
        a1 = final1_sprite;
        a2 = final2_sprite;
        a3 = final3_sprite;
        aw = win;
        tick();
        check("rv_one_cycle", result_valid, 0);
        check("busy_after_result", busy, 0);
        check("win_hold", win, ew);
        check("start_count", n_start - base_s, 1);
        check("rv_count", n_rv - base_r, 1);
        spin_btn = 1'b0;
        repeat (10) tick();
        if (k0 < 0) check("k0", k0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[8];
        logic [2:0] a1, a2, a3;
        logic [1:0] aw;
        int         k0, base_s, base_r, gap, hi, lo;
        bit         pw;

        tbl[0] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 2'd2};
        tbl[1] = '{3'd7, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2, 2'd1};
        tbl[2] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 2'd0};
        tbl[3] = '{3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 2'd2};
        tbl[4] = '{3'd6, 3'd0, 3'd5, 3'd0, 3'd0, 3'd5, 2'd1};
        tbl[5] = '{3'd5, 3'd4, 3'd7, 3'd5, 3'd4, 3'd1, 2'd0};
        tbl[6] = '{3'd2, 3'd7, 3'd1, 3'd2, 3'd1, 3'd1, 2'd1};
        tbl[7] = '{3'd4, 3'd2, 3'd4, 3'd4, 3'd2, 3'd4, 2'd1};

        @(negedge clk);
        do_reset();
        repeat (2) tick();
        check("idle_busy", busy, 0);

        // button held 10 cycles straight out of reset: one spin
        spin(0, '0, 0, 0, 2, 0, a1, a2, a3, aw);

        // 3-cycle glitches, including two separated by one low cycle
        base_s = n_start;
        spin_btn = 1'b1;
        repeat (3) tick();
        spin_btn = 1'b0;
        tick();
        spin_btn = 1'b1;
        repeat (3) tick();
        spin_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("glitch_busy", busy, 0);
        end
        check("glitch_no_start", n_start - base_s, 0);

        for (int v = 0; v < 8; v++) begin
            spin(1, {tbl[v].f3, tbl[v].f2, tbl[v].f1}, 0, 0, 2, 0, a1, a2, a3, aw);
            check("vec_sprites", {a1, a2, a3}, {tbl[v].s1, tbl[v].s2, tbl[v].s3});
            check("vec_win", aw, tbl[v].w);
        end

        // done still high from the last spin
        check("stale_done_level", done, 1);
        spin(0, '0, 3, 6, 3, 0, a1, a2, a3, aw);

        // second press while waiting for done
        spin(0, '0, 5, 0, 14, 1, a1, a2, a3, aw);

        for (int r = 0; r < 12; r++) begin
            gap = $urandom_range(0, 30);
            hi  = $urandom_range(0, 5);
            pw  = 1'($urandom_range(0, 1));
            lo  = pw ? 14 : $urandom_range(1, 8);
            spin(0, '0, gap, hi, lo, pw, a1, a2, a3, aw);
        end

        done = 1'b0;
        base_r = n_rv;
        start_only(k0);
        spin_btn = 1'b0;
`ifdef SPIN_TIMEOUT_EN
        while (cyc < k0 + 8 + TMO) tick();
        check("pre_timeout_busy", busy, 1);
        texp = 1'b1;
        tick();
        check("timeout_busy", busy, 0);
        check("timeout_no_rv", n_rv - base_r, 0);
        repeat (5) tick();
        check("timeout_sticky", timeout, 1);
        start_only(k0);
        spin_btn = 1'b0;
`else
        repeat (70) tick();
        check("wait_forever_busy", busy, 1);
        check("wait_forever_no_rv", n_rv - base_r, 0);
`endif
        repeat (3) tick();
        check("wait_before_reset", busy, 1);
        base_r = n_rv;
        do_reset();
        repeat (20) tick();
        check("reset_abandons_spin", n_rv - base_r, 0);
        check("reset_idle", busy, 0);

        spin(0, '0, 0, 0, 3, 0, a1, a2, a3, aw);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
